// File: rtl/pe_mac_vec.sv
// pe_mac_vec: vector of independent multiply-accumulate lanes behind a
// two-stage valid/ready pipeline. S1 holds per-lane products and the op,
// S2 holds the accumulators and the registered result beat.
module pe_mac_vec #(
  parameter int unsigned LANES = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned ACCW  = 24,
  parameter int unsigned SAT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [1:0]             mode_sel,
  input  logic [LANES*AW-1:0]    a_mul,
  input  logic [LANES*WW-1:0]    b_mul,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [LANES*ACCW-1:0]  pro_sum,
  output logic [LANES-1:0]       ovf
);

  // Product width: unsigned AW times signed WW needs one extra sign bit.
  localparam int unsigned PW     = AW + WW + 1;
  localparam bit          SAT_EN = (SAT != 0);

  typedef enum logic [1:0] {
    OP_ACC      = 2'd0,
    OP_ACC_RELU = 2'd1,
    OP_LOAD     = 2'd2,
    OP_CLEAR    = 2'd3
  } op_e;

  logic s1_vld_q;
  op_e  s1_op_q;
  logic out_vld_q;

  logic s2_load;
  logic s1_load;
  logic accept;

  // S2 advances unless a result is stalled; S1 advances whenever S2 drains it
  // or it is empty, which is exactly when a new beat can be taken.
  assign s2_load = !out_vld_q || out_rdy;
  assign s1_load = !s1_vld_q || s2_load;
  assign accept  = in_vld && s1_load;
  assign in_rdy  = s1_load;
  assign out_vld = out_vld_q;

  // Shared pipeline control: stage valids and the registered op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q  <= 1'b0;
      s1_op_q   <= OP_ACC;
      out_vld_q <= 1'b0;
    end else begin
      if (s1_load) s1_vld_q <= accept;
      if (accept)  s1_op_q  <= op_e'(mode_sel);
      if (s2_load) out_vld_q <= s1_vld_q;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   b_ext;
    logic signed [PW-1:0]   prod_d;
    logic signed [PW-1:0]   s1_prod_q;

    logic signed [ACCW:0]   acc_ext;
    logic signed [ACCW:0]   prod_ext;
    logic signed [ACCW:0]   sum_w;
    logic                   ovf_add;
    logic [ACCW-1:0]        sat_v;
    logic [ACCW-1:0]        add_v;

    logic [ACCW-1:0]        acc_q;
    logic [ACCW-1:0]        acc_d;
    logic [ACCW-1:0]        pro_sum_q;
    logic [ACCW-1:0]        pro_sum_d;
    logic                   ovf_q;
    logic                   ovf_d;

    // Lane product: activation zero-extended, weight sign-extended.
    always_comb begin
      a_ext  = {{(PW-AW){1'b0}}, a_mul[g*AW +: AW]};
      b_ext  = {{(PW-WW){b_mul[g*WW+WW-1]}}, b_mul[g*WW +: WW]};
      prod_d = a_ext * b_ext;
    end

    // S1 product register, written only on an accepted beat.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_prod_q <= '0;
      end else if (accept) begin
        s1_prod_q <= prod_d;
      end
    end

    // Accumulate with one guard bit; a guard/sign disagreement is overflow.
    always_comb begin
      acc_ext  = {acc_q[ACCW-1], acc_q};
      prod_ext = {{(ACCW+1-PW){s1_prod_q[PW-1]}}, s1_prod_q};
      sum_w    = acc_ext + prod_ext;
      ovf_add  = sum_w[ACCW] ^ sum_w[ACCW-1];
      sat_v    = sum_w[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      add_v    = (ovf_add && SAT_EN) ? sat_v : sum_w[ACCW-1:0];

      acc_d     = acc_q;
      pro_sum_d = pro_sum_q;
      ovf_d     = ovf_q;
      case (s1_op_q)
        OP_ACC: begin
          acc_d     = add_v;
          pro_sum_d = add_v;
          ovf_d     = ovf_q | ovf_add;
        end
        OP_ACC_RELU: begin
          acc_d     = add_v;
          pro_sum_d = add_v[ACCW-1] ? '0 : add_v;
          ovf_d     = ovf_q | ovf_add;
        end
        OP_LOAD: begin
          acc_d     = prod_ext[ACCW-1:0];
          pro_sum_d = prod_ext[ACCW-1:0];
        end
        OP_CLEAR: begin
          acc_d     = '0;
          pro_sum_d = '0;
          ovf_d     = 1'b0;
        end
        default: ;
      endcase
    end

    // S2 lane state: commits only when a valid S1 beat moves forward.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_q     <= '0;
        pro_sum_q <= '0;
        ovf_q     <= 1'b0;
      end else if (s2_load && s1_vld_q) begin
        acc_q     <= acc_d;
        pro_sum_q <= pro_sum_d;
        ovf_q     <= ovf_d;
      end
    end

    assign pro_sum[g*ACCW +: ACCW] = pro_sum_q;
    assign ovf[g]                  = ovf_q;
  end

endmodule

// File: tb/tb_pe_mac_vec.sv
// Bench for pe_mac_vec: wrap and saturate instances share one stimulus
// stream; a per-lane sequential model fills a scoreboard on acceptance.
module tb_pe_mac_vec;

  localparam int unsigned LANES = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned WW    = 8;
  localparam int unsigned ACCW  = 24;

  localparam longint MOD  = 64'sd1 << ACCW;
  localparam longint MAXV = MOD / 2 - 1;
  localparam longint MINV = -(MOD / 2);

  localparam logic [1:0] M_ACC  = 2'd0;
  localparam logic [1:0] M_RELU = 2'd1;
  localparam logic [1:0] M_LOAD = 2'd2;
  localparam logic [1:0] M_CLR  = 2'd3;

  logic                  clk;
  logic                  reset;
  logic                  in_vld;
  logic [1:0]            mode_sel;
  logic [LANES*AW-1:0]   a_mul;
  logic [LANES*WW-1:0]   b_mul;
  logic                  out_rdy;
  logic                  in_rdy0, in_rdy1;
  logic                  out_vld0, out_vld1;
  logic [LANES*ACCW-1:0] pro_sum0, pro_sum1;
  logic [LANES-1:0]      ovf0, ovf1;

  pe_mac_vec #(.LANES(LANES), .AW(AW), .WW(WW), .ACCW(ACCW), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy0),
    .mode_sel(mode_sel), .a_mul(a_mul), .b_mul(b_mul),
    .out_vld(out_vld0), .out_rdy(out_rdy), .pro_sum(pro_sum0), .ovf(ovf0)
  );

  pe_mac_vec #(.LANES(LANES), .AW(AW), .WW(WW), .ACCW(ACCW), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy1),
    .mode_sel(mode_sel), .a_mul(a_mul), .b_mul(b_mul),
    .out_vld(out_vld1), .out_rdy(out_rdy), .pro_sum(pro_sum1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*ACCW-1:0] ps0;
    logic [LANES*ACCW-1:0] ps1;
    logic [LANES-1:0]      ov0;
    logic [LANES-1:0]      ov1;
  } exp_t;

  exp_t        sbq[$];
  longint      acc_m [2][LANES];
  logic [LANES-1:0] ovf_m [2];
  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  int          n_out = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int l = 0; l < LANES; l++) acc_m[s][l] = 0;
      ovf_m[s] = '0;
    end
    sbq.delete();
  endtask

  // Sequential golden model: index 0 wraps, index 1 saturates.
  task automatic push_model();
    exp_t                  e;
    longint                p, sum, r;
    logic [AW-1:0]         al;
    logic signed [WW-1:0]  bl;
    logic [LANES*ACCW-1:0] psv [2];
    for (int s = 0; s < 2; s++) begin
      psv[s] = '0;
      for (int l = 0; l < LANES; l++) begin
        al = a_mul[l*AW +: AW];
        bl = b_mul[l*WW +: WW];
        p  = longint'(al) * longint'(bl);
        r  = 0;
        case (mode_sel)
          M_LOAD: begin acc_m[s][l] = p; r = p; end
          M_CLR:  begin acc_m[s][l] = 0; r = 0; ovf_m[s][l] = 1'b0; end
          default: begin
            sum = acc_m[s][l] + p;
            if (sum > MAXV) begin
              ovf_m[s][l] = 1'b1;
              sum = (s == 1) ? MAXV : sum - MOD;
            end else if (sum < MINV) begin
              ovf_m[s][l] = 1'b1;
              sum = (s == 1) ? MINV : sum + MOD;
            end
            acc_m[s][l] = sum;
            r = (mode_sel == M_RELU && sum < 0) ? 0 : sum;
          end
        endcase
        psv[s][l*ACCW +: ACCW] = r[ACCW-1:0];
      end
    end
    e.ps0 = psv[0];
    e.ps1 = psv[1];
    e.ov0 = ovf_m[0];
    e.ov1 = ovf_m[1];
    sbq.push_back(e);
    n_acc++;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_unexpected_out", {127'd0, out_vld0}, 128'd0);
    end else begin
      e = sbq.pop_front();
      chk("out_vld_sat", {127'd0, out_vld1}, 128'd1);
      chk("pro_sum_wrap", pro_sum0, e.ps0);
      chk("pro_sum_sat",  pro_sum1, e.ps1);
      chk("ovf_wrap", ovf0, e.ov0);
      chk("ovf_sat",  ovf1, e.ov1);
      n_out++;
    end
  endtask

  // One clock cycle: drive after the falling edge, sample mid-cycle.
  task automatic cyc(input logic v, input logic [1:0] m, input logic [LANES*AW-1:0] a,
                     input logic [LANES*WW-1:0] b, input logic ordy);
    in_vld   = v;
    mode_sel = m;
    a_mul    = a;
    b_mul    = b;
    out_rdy  = ordy;
    #1;
    if (out_vld0) begin
      if (out_rdy) begin
        pop_check();
      end else if (sbq.size() > 0) begin
        chk("stall_hold_wrap", pro_sum0, sbq[0].ps0);
        chk("stall_hold_sat",  pro_sum1, sbq[0].ps1);
      end
    end
    if (reset && in_vld && in_rdy0) push_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sbq.size() == 0 && !out_vld0) break;
      cyc(1'b0, M_ACC, '0, '0, 1'b1);
    end
    chk("drain_empty", 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, o0;
    logic [LANES*AW-1:0] ra;
    logic [LANES*WW-1:0] rb;
    logic [1:0]          rm;
    int                  rsel;

    reset = 1'b0; in_vld = 1'b0; mode_sel = '0; a_mul = '0; b_mul = '0; out_rdy = 1'b0;
    model_reset();
    #3;
    chk("rst_pro_sum", pro_sum0, 128'd0);
    chk("rst_out_vld", {127'd0, out_vld0}, 128'd0);
    chk("rst_ovf", ovf1, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_rdy", {127'd0, in_rdy0}, 128'd1);
    @(negedge clk);

    // LOAD then ACC on every lane, with latency checks
    cyc(1'b1, M_LOAD, {4{8'd5}}, {4{8'd3}}, 1'b1);
    chk("lat_not_yet", {127'd0, out_vld0}, 128'd0);
    cyc(1'b1, M_ACC, {4{8'd10}}, {4{8'hFE}}, 1'b1);
    chk("lat_load", {127'd0, out_vld0}, 128'd1);
    chk("load_lanes", pro_sum0, {4{24'd15}});
    cyc(1'b0, M_ACC, '0, '0, 1'b1);
    chk("lat_acc", {127'd0, out_vld0}, 128'd1);
    chk("acc_lanes", pro_sum0, {4{24'hFFFFFB}});

    // ReLU clamps the output but the accumulator keeps -6
    cyc(1'b1, M_RELU, {4{8'd1}}, {4{8'hFF}}, 1'b1);
    cyc(1'b1, M_ACC, '0, '0, 1'b1);
    chk("relu_lane0", pro_sum0[23:0], 24'd0);
    cyc(1'b0, M_ACC, '0, '0, 1'b1);
    chk("relu_acc_kept", pro_sum0[23:0], 24'hFFFFFA);
    drain(8);

    // Drive lane 0 to 8388600, then overflow it; other lanes stay at 0
    n0 = n_acc; o0 = n_out;
    cyc(1'b1, M_CLR, '0, '0, 1'b1);
    cyc(1'b1, M_LOAD, {24'd0, 8'd255}, {24'd0, 8'd127}, 1'b1);
    for (int i = 0; i < 258; i++) cyc(1'b1, M_ACC, {24'd0, 8'd255}, {24'd0, 8'd127}, 1'b1);
    cyc(1'b1, M_ACC, {24'd0, 8'd177}, {24'd0, 8'd5}, 1'b1);
    cyc(1'b1, M_ACC, {24'd0, 8'd255}, {24'd0, 8'd127}, 1'b1);
    chk("thru_accepts", 128'(n_acc - n0), 128'd262);
    chk("thru_results", 128'(n_out - o0), 128'd260);
    drain(8);
    chk("sat_lane0", pro_sum1[23:0], 24'h7FFFFF);
    chk("sat_ovf", ovf1, 4'b0001);
    chk("wrap_lane0", pro_sum0[23:0], 24'h807E79);
    chk("wrap_ovf", ovf0, 4'b0001);

    // LOAD keeps the sticky flag, CLEAR drops it
    cyc(1'b1, M_LOAD, {24'd0, 8'd1}, {24'd0, 8'd1}, 1'b1);
    drain(8);
    chk("load_keeps_ovf", ovf0, 4'b0001);
    cyc(1'b1, M_CLR, '0, '0, 1'b1);
    drain(8);
    chk("clear_ovf", ovf1, 4'b0000);

    // Stall: only two beats fit, then in_rdy drops
    n0 = n_acc; o0 = n_out;
    for (int k = 0; k < 5; k++) cyc(1'b1, M_ACC, {4{8'(k + 1)}}, {4{8'd1}}, 1'b0);
    chk("stall_accepts", 128'(n_acc - n0), 128'd2);
    #1;
    chk("stall_rdy_wrap", {127'd0, in_rdy0}, 128'd0);
    chk("stall_rdy_sat", {127'd0, in_rdy1}, 128'd0);
    @(negedge clk);
    drain(10);
    chk("stall_results", 128'(n_out - o0), 128'd2);

    // Random regression on both instances
    n0 = n_acc;
    for (int c = 0; c < 20000 && (n_acc - n0) < 1000; c++) begin
      ra   = $urandom();
      rb   = $urandom();
      rsel = $urandom_range(0, 9);
      rm   = (rsel < 5) ? M_ACC : (rsel < 7) ? M_RELU : (rsel < 9) ? M_LOAD : M_CLR;
      cyc($urandom_range(0, 3) != 0, rm, ra, rb, $urandom_range(0, 3) != 0);
    end
    chk("rand_accepts", 128'(n_acc - n0), 128'd1000);
    drain(10);

    // Reset while a result is stalled
    cyc(1'b1, M_ACC, {4{8'd3}}, {4{8'd3}}, 1'b0);
    cyc(1'b0, M_ACC, '0, '0, 1'b0);
    chk("pre_rst_vld", {127'd0, out_vld0}, 128'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_pro_sum_wrap", pro_sum0, 128'd0);
    chk("mid_rst_pro_sum_sat", pro_sum1, 128'd0);
    chk("mid_rst_out_vld", {127'd0, out_vld1}, 128'd0);
    chk("mid_rst_ovf", ovf0, 128'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_rdy", {127'd0, in_rdy1}, 128'd1);
    @(negedge clk);
    cyc(1'b1, M_CLR, '0, '0, 1'b1);
    cyc(1'b1, M_ACC, {4{8'd2}}, {4{8'd2}}, 1'b1);
    drain(8);
    chk("post_rst_wrap", pro_sum0, {4{24'd4}});
    chk("post_rst_sat", pro_sum1, {4{24'd4}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
